proj_frag_assembler: RTL and testbench

PROJ_FRAG_ASSEMBLER -- requirements
Module: proj_frag_assembler

---
 rtl/proj_pkg.sv | 6 +
 rtl/proj_frag_assembler_if.sv | 33 +++
 rtl/proj_frag_assembler.sv | 130 +++++++++++++
 tb/tb_proj_frag_assembler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared constants for the fragment datapath
package proj_pkg;

  localparam int BASE_LEN = 2;

endpackage

// File: rtl/proj_frag_assembler_if.sv
// rtl/proj_frag_assembler_if.sv - serial beat input and assembled fragment output bundle
interface proj_frag_assembler_if #(
  parameter int FRAG_LEN          = 8,
  parameter int FRAG_PART         = 2,
  parameter int INDICE_LEN        = 5,
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
);

  logic                         in_valid;
  logic                         in_ready;
  logic [FRAG_PART-1:0]         in_gfm;
  logic [SIGNED_INDICE_LEN-1:0] in_index;
  logic                         out_valid;
  logic                         out_ready;
  logic [FRAG_LEN-1:0]          out_fragment;
  logic [INDICE_LEN-1:0]        out_kmer_index;
  logic                         out_last;
  logic                         err_index;
  logic                         err_range;

  modport master (
    output in_valid, in_gfm, in_index, out_ready,
    input  in_ready, out_valid, out_fragment, out_kmer_index, out_last,
           err_index, err_range
  );

  modport slave (
    input  in_valid, in_gfm, in_index, out_ready,
    output in_ready, out_valid, out_fragment, out_kmer_index, out_last,
           err_index, err_range
  );

endinterface

// File: rtl/proj_frag_assembler.sv
// rtl/proj_frag_assembler.sv - reassembles serial fragment parts into a buffered fragment with restored k-mer index
module proj_frag_assembler #(
  parameter int KMER_LEN          = 4,
  parameter int FRAG_LEN          = 8,
  parameter int BASE_LEN          = proj_pkg::BASE_LEN,
  parameter int INDICES_COUNT     = 3,
  parameter int INDICE_LEN        = 5,
  parameter int FRAG_PART         = 2,
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  proj_frag_assembler_if.slave  bus
);

  localparam int PARTS  = FRAG_LEN / FRAG_PART;
  localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;
  localparam int PCW    = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int FCW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;

  localparam logic [PCW-1:0]               LAST_PART = PCW'(PARTS - 1);
  localparam logic [FCW-1:0]               LAST_FRAG = FCW'(INDICES_COUNT - 1);
  localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_V  = SIGNED_INDICE_LEN'(OFFSET);

  // BASE_LEN only travels with the datapath; nothing here depends on it.
  if (BASE_LEN < 1) begin : g_base_len_unused
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [PCW-1:0]               part_q, part_d;
  logic [FCW-1:0]               frag_q, frag_d;
  logic [FRAG_LEN-1:0]          shift_q, shift_d;
  logic [SIGNED_INDICE_LEN-1:0] idx_q, idx_d;
  logic [FRAG_LEN-1:0]          out_frag_q, out_frag_d;
  logic [INDICE_LEN-1:0]        out_kidx_q, out_kidx_d;
  logic                         out_last_q, out_last_d;
  logic                         err_index_q, err_index_d;
  logic                         err_range_q, err_range_d;

  logic                         in_ready;
  logic                         accept;
  logic                         final_beat;
  logic [SIGNED_INDICE_LEN-1:0] cur_idx;
  logic [SIGNED_INDICE_LEN-1:0] restored;

  assign in_ready = (state_q == ST_EMPTY) | bus.out_ready;

  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    frag_d      = frag_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    out_frag_d  = out_frag_q;
    out_kidx_d  = out_kidx_q;
    out_last_d  = out_last_q;
    err_index_d = err_index_q;
    err_range_d = err_range_q;

    accept     = bus.in_valid & in_ready;
    final_beat = accept & (part_q == LAST_PART);
    // A single-part fragment must use the live index, not the stale capture.
    cur_idx    = (part_q == '0) ? bus.in_index : idx_q;
    restored   = cur_idx + OFFSET_V;

    if (accept) begin
      shift_d[FRAG_PART*part_q +: FRAG_PART] = bus.in_gfm;
      part_d = final_beat ? '0 : part_q + 1'b1;
      if (part_q == '0) begin
        idx_d = bus.in_index;
      end else if (bus.in_index != idx_q) begin
        err_index_d = 1'b1;
      end
    end

    case (state_q)
      ST_EMPTY: if (final_beat) state_d = ST_FULL;
      ST_FULL:  if (!final_beat && bus.out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (final_beat) begin
      out_frag_d = shift_d;
      out_kidx_d = restored[INDICE_LEN-1:0];
      out_last_d = (frag_q == LAST_FRAG);
      frag_d     = (frag_q == LAST_FRAG) ? '0 : frag_q + 1'b1;
      if (restored[INDICE_LEN]) err_range_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      part_q      <= '0;
      frag_q      <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      out_frag_q  <= '0;
      out_kidx_q  <= '0;
      out_last_q  <= 1'b0;
      err_index_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      part_q      <= part_d;
      frag_q      <= frag_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      out_frag_q  <= out_frag_d;
      out_kidx_q  <= out_kidx_d;
      out_last_q  <= out_last_d;
      err_index_q <= err_index_d;
      err_range_q <= err_range_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == ST_FULL);
  assign bus.out_fragment   = out_frag_q;
  assign bus.out_kmer_index = out_kidx_q;
  assign bus.out_last       = out_last_q;
  assign bus.err_index      = err_index_q;
  assign bus.err_range      = err_range_q;

endmodule

// File: tb/tb_proj_frag_assembler.sv
// tb/tb_proj_frag_assembler.sv - randomized bench for proj_frag_assembler against a queue-based model
module tb_proj_frag_assembler;

  localparam int KMER_LEN      = 4;
  localparam int FRAG_LEN      = 8;
  localparam int INDICES_COUNT = 3;
  localparam int INDICE_LEN    = 5;
  localparam int FRAG_PART     = 2;
  localparam int SIL           = INDICE_LEN + 1;
  localparam int PARTS         = FRAG_LEN / FRAG_PART;
  localparam int OFFSET        = (FRAG_LEN - KMER_LEN) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proj_frag_assembler_if #(
    .FRAG_LEN(FRAG_LEN), .FRAG_PART(FRAG_PART),
    .INDICE_LEN(INDICE_LEN), .SIGNED_INDICE_LEN(SIL)
  ) bus ();

  proj_frag_assembler #(
    .KMER_LEN(KMER_LEN), .FRAG_LEN(FRAG_LEN), .INDICES_COUNT(INDICES_COUNT),
    .INDICE_LEN(INDICE_LEN), .FRAG_PART(FRAG_PART), .SIGNED_INDICE_LEN(SIL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  int m_gfm[$];
  int m_idx[$];
  bit m_full;
  int m_frag;
  int m_kidx;
  bit m_last;
  int m_done;
  bit m_err_index;
  bit m_err_range;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gfm.delete();
    m_idx.delete();
    m_full = 0;
    m_frag = 0;
    m_kidx = 0;
    m_last = 0;
    m_done = 0;
    m_err_index = 0;
    m_err_range = 0;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic step(input bit v, input int gfm, input int idx, input bit ordy);
    bit exp_ready;
    bit completed;
    int f;
    int restored;
    bus.in_valid  = v;
    bus.in_gfm    = gfm[FRAG_PART-1:0];
    bus.in_index  = idx[SIL-1:0];
    bus.out_ready = ordy;
    @(negedge clk);
    exp_ready = !m_full || ordy;
    check_eq("in_ready", bus.in_ready, exp_ready);
    check_eq("out_valid", bus.out_valid, m_full);
    if (m_full) begin
      check_eq("out_fragment", bus.out_fragment, m_frag);
      check_eq("out_kmer_index", bus.out_kmer_index, m_kidx);
      check_eq("out_last", bus.out_last, m_last);
    end
    check_eq("err_index", bus.err_index, m_err_index);
    check_eq("err_range", bus.err_range, m_err_range);
    completed = 0;
    if (v && exp_ready) begin
      if (m_gfm.size() > 0 && idx != m_idx[0]) m_err_index = 1;
      m_gfm.push_back(gfm % (1 << FRAG_PART));
      m_idx.push_back(idx);
      if (m_gfm.size() == PARTS) begin
        f = 0;
        foreach (m_gfm[p]) f += m_gfm[p] * (1 << (FRAG_PART * p));
        restored = (m_idx[0] + OFFSET) % (1 << SIL);
        m_frag = f;
        m_kidx = restored % (1 << INDICE_LEN);
        if (restored >= (1 << INDICE_LEN)) m_err_range = 1;
        m_last = (m_done % INDICES_COUNT) == INDICES_COUNT - 1;
        m_done++;
        m_gfm.delete();
        m_idx.delete();
        completed = 1;
      end
    end
    if (completed) m_full = 1;
    else if (m_full && ordy) m_full = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frag(input int val, input int idx, input bit ordy);
    for (int p = 0; p < PARTS; p++)
      step(1, (val >> (FRAG_PART * p)) % (1 << FRAG_PART), idx, ordy);
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_fragment", bus.out_fragment, 0);
    check_eq("rst_out_kmer_index", bus.out_kmer_index, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    int frag_idx;
    int beat_idx;
    bus.in_valid  = 0;
    bus.in_gfm    = '0;
    bus.in_index  = '0;
    bus.out_ready = 0;
    model_reset();
    do_reset();

    step(1, 1, 4, 1);
    step(1, 2, 4, 1);
    step(1, 3, 4, 1);
    step(1, 0, 4, 1);
    check_eq("basic_frag", bus.out_fragment, 8'h39);
    check_eq("basic_kidx", bus.out_kmer_index, 6);
    check_eq("basic_last", bus.out_last, 0);

    send_frag(8'hC3, 10, 1);
    send_frag(8'h7E, 11, 1);
    check_eq("third_last", bus.out_last, 1);
    send_frag(8'h12, 12, 1);
    check_eq("fourth_last", bus.out_last, 0);
    step(0, 0, 0, 1);

    step(1, 0, 4, 1);
    step(1, 1, 4, 1);
    step(1, 2, 5, 1);
    step(1, 3, 4, 1);
    check_eq("idxchg_err", bus.err_index, 1);
    check_eq("idxchg_kidx", bus.out_kmer_index, 6);
    step(0, 0, 0, 1);
    check_eq("idxchg_sticky", bus.err_index, 1);

    send_frag(8'h55, 31, 1);
    check_eq("range_err", bus.err_range, 1);
    check_eq("range_kidx", bus.out_kmer_index, 1);

    do_reset();
    send_frag(8'hA5, 7, 0);
    for (int i = 0; i < 3; i++) step(1, 3, 9, 0);
    check_eq("stall_frag", bus.out_fragment, 8'hA5);
    send_frag(8'h5A, 9, 1);
    step(0, 0, 0, 1);

    step(1, 2, 3, 1);
    step(1, 1, 3, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    send_frag(8'h39, 4, 1);
    check_eq("post_rst_frag", bus.out_fragment, 8'h39);
    step(0, 0, 0, 1);

    frag_idx = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 400 == 0) do_reset();
      if (m_gfm.size() == 0) frag_idx = $urandom_range(0, (1 << SIL) - 1);
      beat_idx = ($urandom % 25 == 0) ? $urandom_range(0, (1 << SIL) - 1) : frag_idx;
      step(($urandom % 5) != 0, $urandom_range(0, (1 << FRAG_PART) - 1), beat_idx,
           ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
